// File: rtl/drv_status_poller_if.sv
// SPI bus between the status poller (master) and the chain of gate-driver chips (slave).
// One active-low chip select per driver; sck is mode 1 (CPOL=0, CPHA=1).
interface drv_status_poller_if #(
  parameter int NUM_MOTORS = 5
);
  logic                  sck;
  logic                  mosi;
  logic                  miso;
  logic [NUM_MOTORS-1:0] drv_ncs;

  modport master (output sck, output mosi, output drv_ncs, input miso);
  modport slave  (input sck, input mosi, input drv_ncs, output miso);
endinterface

// File: rtl/drv_status_poller.sv
// Round-robin SPI poller that reads status register 0 from each enabled gate driver
// and keeps a per-motor valid/fault view of the replies.
module drv_status_poller #(
  parameter int NUM_MOTORS = 5,
  parameter int SCK_DIV    = 4,
  parameter int CS_SETUP   = 2,
  parameter int CS_IDLE    = 4
) (
  input  logic                  sysclk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [NUM_MOTORS-1:0] poll_mask,
  drv_status_poller_if.master   spi,
  output logic                  frame_done,
  output logic [2:0]            frame_motor,
  output logic [15:0]           frame_data,
  output logic [NUM_MOTORS-1:0] valid,
  output logic [NUM_MOTORS-1:0] fault,
  output logic                  fault_any
);
  localparam logic [15:0] TX_WORD = 16'h8000;
  localparam int IW      = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1;
  localparam int M1      = (CS_SETUP > 2*SCK_DIV) ? CS_SETUP : 2*SCK_DIV;
  localparam int CNT_MAX = (M1 > CS_IDLE) ? M1 : CS_IDLE;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t                state;
  logic [IW-1:0]         idx;
  logic [CW-1:0]         cnt;
  logic [3:0]            bit_cnt;
  logic [15:0]           tx_sh;
  logic [15:0]           rx_sh;
  logic [NUM_MOTORS-1:0] seen;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == IW'(NUM_MOTORS - 1)) ? '0 : i + IW'(1);
  endfunction

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      bit_cnt     <= '0;
      tx_sh       <= '0;
      rx_sh       <= '0;
      seen        <= '0;
      spi.sck     <= 1'b0;
      spi.mosi    <= 1'b0;
      spi.drv_ncs <= '1;
      frame_done  <= 1'b0;
      frame_motor <= '0;
      frame_data  <= '0;
      valid       <= '0;
      fault       <= '0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (en) begin
            if (poll_mask[idx]) begin
              spi.drv_ncs <= ~(NUM_MOTORS'(1) << idx);
              spi.mosi    <= TX_WORD[15];
              tx_sh       <= TX_WORD;
              cnt         <= '0;
              bit_cnt     <= '0;
              state       <= SETUP;
            end else begin
              idx <= next_idx(idx);
            end
          end
        end
        SETUP: begin
          if (cnt == CW'(CS_SETUP - 1)) begin
            spi.sck  <= 1'b1;
            spi.mosi <= tx_sh[15];
            tx_sh    <= {tx_sh[14:0], 1'b0};
            cnt      <= '0;
            state    <= SHIFT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        SHIFT: begin
          // cnt walks one full SCK period: fall/sample at mid-period, next rise at the end
          if (cnt == CW'(SCK_DIV - 1)) begin
            spi.sck <= 1'b0;
            rx_sh   <= {rx_sh[14:0], spi.miso};
            cnt     <= cnt + CW'(1);
          end else if (cnt == CW'(2*SCK_DIV - 1)) begin
            cnt <= '0;
            if (bit_cnt == 4'd15) begin
              state <= HOLD;
            end else begin
              bit_cnt  <= bit_cnt + 4'd1;
              spi.sck  <= 1'b1;
              spi.mosi <= tx_sh[15];
              tx_sh    <= {tx_sh[14:0], 1'b0};
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HOLD: begin
          if (cnt == CW'(CS_SETUP - 1)) begin
            spi.drv_ncs <= '1;
            spi.mosi    <= 1'b0;
            frame_done  <= 1'b1;
            frame_motor <= 3'(idx);
            frame_data  <= rx_sh;
            // first reply after reset answers a command we never sent
            if (seen[idx]) begin
              valid[idx] <= 1'b1;
              fault[idx] <= rx_sh[10];
            end
            seen[idx] <= 1'b1;
            cnt       <= '0;
            state     <= GAP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        GAP: begin
          if (cnt == CW'(CS_IDLE - 1)) begin
            idx   <= next_idx(idx);
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fault_any = |(fault & valid);

endmodule

// File: tb/tb_drv_status_poller.sv
// Randomized bench for drv_status_poller: an SPI slave model feeds replies and a
// frame-level reference model checks chip-select order, timing and status outputs.
module tb_drv_status_poller;
  localparam int NM       = 5;
  localparam int SCK_DIV  = 4;
  localparam int CS_SETUP = 2;
  localparam int CS_IDLE  = 4;
  localparam int CS_LOW   = CS_SETUP + 32*SCK_DIV + CS_SETUP;

  logic          sysclk = 1'b0;
  logic          rst_n  = 1'b1;
  logic          en     = 1'b0;
  logic [NM-1:0] poll_mask = '0;
  logic          frame_done;
  logic [2:0]    frame_motor;
  logic [15:0]   frame_data;
  logic [NM-1:0] valid;
  logic [NM-1:0] fault;
  logic          fault_any;

  drv_status_poller_if #(.NUM_MOTORS(NM)) spi ();

  drv_status_poller #(
    .NUM_MOTORS(NM),
    .SCK_DIV   (SCK_DIV),
    .CS_SETUP  (CS_SETUP),
    .CS_IDLE   (CS_IDLE)
  ) dut (
    .sysclk     (sysclk),
    .rst_n      (rst_n),
    .en         (en),
    .poll_mask  (poll_mask),
    .spi        (spi.master),
    .frame_done (frame_done),
    .frame_motor(frame_motor),
    .frame_data (frame_data),
    .valid      (valid),
    .fault      (fault),
    .fault_any  (fault_any)
  );

  always #5 sysclk = ~sysclk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // SPI slave: new reply word per frame, bits presented on sck rise, mosi captured on sck fall
  int          slave_mode = 0;
  int          slv_m;
  logic [15:0] slave_word = '0;
  logic [15:0] mosi_cap   = '0;
  int          sck_rises  = 0;
  logic        cs_all_high;
  assign cs_all_high = &spi.drv_ncs;

  initial spi.miso = 1'b0;

  always @(negedge cs_all_high) begin
    slv_m = 0;
    for (int m = 0; m < NM; m++) if (!spi.drv_ncs[m]) slv_m = m;
    if (slave_mode == 0) slave_word = (slv_m == 2) ? 16'h0400 : 16'h0000;
    else                 slave_word = 16'($urandom);
    mosi_cap  = '0;
    sck_rises = 0;
  end

  always @(posedge spi.sck) begin
    if (sck_rises < 16) spi.miso = slave_word[15 - sck_rises];
    sck_rises++;
  end

  always @(negedge spi.sck) mosi_cap = {mosi_cap[14:0], spi.mosi};

  // Frame-level reference model
  logic [NM-1:0] m_seen, m_valid, m_fault, prev_ncs, mask_q;
  logic [15:0]   m_data;
  int            m_motor, m_idx, active_m, low_cnt;
  logic          en_q, exp_fd;
  int            n_falls = 0, n_fd = 0, sck_hi_cnt = 0, last_fall_m = -1, last_fd_m = -1;
  int            fall_cnt [NM];
  int            order_q [$];

  initial begin
    m_seen = '0; m_valid = '0; m_fault = '0; prev_ncs = '1; mask_q = '0;
    m_data = '0; m_motor = 0; m_idx = 0; active_m = -1; low_cnt = 0; en_q = 1'b0;
    for (int m = 0; m < NM; m++) fall_cnt[m] = 0;
  end

  function automatic int next_expected(input logic [NM-1:0] mask, input int from);
    for (int k = 0; k < NM; k++)
      if (mask[(from + k) % NM]) return (from + k) % NM;
    return -1;
  endfunction

  always @(negedge sysclk) begin
    if (!rst_n) begin
      chk("rst_ncs",   32'(spi.drv_ncs), 32'({NM{1'b1}}));
      chk("rst_sck",   32'(spi.sck), 0);
      chk("rst_mosi",  32'(spi.mosi), 0);
      chk("rst_fd",    32'(frame_done), 0);
      chk("rst_fdata", 32'(frame_data), 0);
      chk("rst_fmot",  32'(frame_motor), 0);
      chk("rst_valid", 32'(valid), 0);
      chk("rst_fault", 32'(fault), 0);
      chk("rst_fany",  32'(fault_any), 0);
      m_seen = '0; m_valid = '0; m_fault = '0; m_data = '0; m_motor = 0;
      m_idx = 0; active_m = -1; low_cnt = 0;
    end else begin
      chk("one_cs", 32'($countones(~spi.drv_ncs) <= 1), 1);
      if (&spi.drv_ncs) chk("sck_idle", 32'(spi.sck), 0);
      if (spi.sck) sck_hi_cnt++;
      exp_fd = 1'b0;
      if (active_m >= 0) begin
        if (spi.drv_ncs[active_m]) begin
          exp_fd = 1'b1;
          chk("cs_low_cycles", low_cnt, CS_LOW);
          chk("mosi_word",     32'(mosi_cap), 32'h8000);
          chk("sck_pulses",    sck_rises, 16);
          if (m_seen[active_m]) begin
            m_valid[active_m] = 1'b1;
            m_fault[active_m] = slave_word[10];
          end
          m_seen[active_m] = 1'b1;
          m_data    = slave_word;
          m_motor   = active_m;
          m_idx     = (active_m + 1) % NM;
          last_fd_m = active_m;
          active_m  = -1;
        end else begin
          low_cnt++;
        end
      end else begin
        for (int m = 0; m < NM; m++) begin
          if (prev_ncs[m] && !spi.drv_ncs[m]) begin
            chk("cs_needs_en", 32'(en_q), 1);
            chk("cs_order", m, next_expected(mask_q, m_idx));
            active_m    = m;
            low_cnt     = 1;
            last_fall_m = m;
            n_falls++;
            fall_cnt[m]++;
            order_q.push_back(m);
          end
        end
      end
      chk("frame_done",  32'(frame_done), 32'(exp_fd));
      if (frame_done) n_fd++;
      chk("frame_data",  32'(frame_data), 32'(m_data));
      chk("frame_motor", 32'(frame_motor), m_motor);
      chk("valid",       32'(valid), 32'(m_valid));
      chk("fault",       32'(fault), 32'(m_fault));
      chk("fault_any",   32'(fault_any), 32'(|(m_fault & m_valid)));
    end
    prev_ncs = spi.drv_ncs;
    en_q     = en;
    mask_q   = poll_mask;
  end

  task automatic wait_fd(input int n, input string nm);
    int target;
    target = n_fd + n;
    for (int k = 0; k < n*400 + 400; k++) begin
      @(posedge sysclk);
      if (n_fd >= target) break;
    end
    chk(nm, 32'(n_fd >= target), 1);
  endtask

  task automatic wait_fall(input string nm);
    int target;
    target = n_falls + 1;
    for (int k = 0; k < 2000; k++) begin
      @(posedge sysclk);
      if (n_falls >= target) break;
    end
    chk(nm, 32'(n_falls >= target), 1);
  endtask

  initial begin
    int fd0, falls0, hi0, others0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge sysclk);
    #1;
    chk("reset_ncs",  32'(spi.drv_ncs), 32'h1f);
    chk("reset_sck",  32'(spi.sck), 0);
    chk("reset_valid",32'(valid), 0);
    chk("reset_fany", 32'(fault_any), 0);
    rst_n = 1'b1;

    // round robin, motor 2 reports FAULT
    order_q.delete();
    en = 1'b1; poll_mask = 5'b11111;
    wait_fd(10, "rr_timeout");
    #1;
    for (int i = 0; i < 10; i++) chk("rr_order", (i < order_q.size()) ? order_q[i] : -1, i % 5);
    chk("rr_valid", 32'(valid), 32'h1f);
    chk("rr_fault", 32'(fault), 32'h04);
    chk("rr_fany",  32'(fault_any), 1);

    // single motor mask
    en = 1'b0;
    repeat (300) @(posedge sysclk);
    #1;
    others0 = fall_cnt[0] + fall_cnt[1] + fall_cnt[3] + fall_cnt[4];
    poll_mask = 5'b00100; en = 1'b1;
    wait_fd(3, "mask_timeout");
    chk("mask_motor",  last_fd_m, 2);
    chk("mask_others", fall_cnt[0] + fall_cnt[1] + fall_cnt[3] + fall_cnt[4], others0);

    // enable drop mid-SHIFT
    wait_fall("drop_fall0");
    #1 poll_mask = 5'b11111;
    wait_fall("drop_fall1");
    repeat (CS_SETUP + 49) @(posedge sysclk);
    #1;
    fd0 = n_fd; falls0 = n_falls;
    en = 1'b0;
    repeat (1200) @(posedge sysclk);
    chk("drop_one_fd",   n_fd - fd0, 1);
    chk("drop_no_cs",    n_falls - falls0, 0);

    // random replies, mid-frame mask changes and enable pauses
    slave_mode = 1;
    #1 en = 1'b1;
    for (int it = 0; it < 30; it++) begin
      wait_fall("rand_fall");
      repeat ($urandom_range(0, 100)) @(posedge sysclk);
      #1;
      poll_mask = NM'($urandom_range(1, (1 << NM) - 1));
      if ($urandom_range(0, 3) == 0) begin
        en = 1'b0;
        repeat (200) @(posedge sysclk);
        #1;
        poll_mask = NM'($urandom_range(1, (1 << NM) - 1));
        en = 1'b1;
      end
    end
    wait_fd(1, "rand_last_fd");

    // all masked
    #1 en = 1'b0;
    repeat (300) @(posedge sysclk);
    #1;
    poll_mask = '0; en = 1'b1;
    falls0 = n_falls; hi0 = sck_hi_cnt;
    repeat (1000) @(posedge sysclk);
    chk("masked_no_cs",  n_falls - falls0, 0);
    chk("masked_no_sck", sck_hi_cnt - hi0, 0);

    // resynchronise idx, then reset in the middle of SHIFT
    #1 en = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge sysclk);
    #1 rst_n = 1'b1;
    slave_mode = 0;
    poll_mask = 5'b11111; en = 1'b1;
    wait_fall("mrst_fall");
    repeat (CS_SETUP + 20) @(posedge sysclk);
    fd0 = n_fd;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_ncs_now", 32'(spi.drv_ncs), 32'h1f);
    chk("mrst_fd_now",  32'(frame_done), 0);
    chk("mrst_sck_now", 32'(spi.sck), 0);
    repeat (2) @(posedge sysclk);
    #1 rst_n = 1'b1;
    chk("mrst_no_fd", n_fd - fd0, 0);
    wait_fall("mrst_next_fall");
    chk("mrst_next_motor", last_fall_m, 0);
    wait_fd(1, "mrst_fd");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
